frame_scheduler: RTL

- Sequences the single shared rectangle plotter among the game objects once per video frame: erase old bird and wall, pulse the game logic to advance, then redraw the wall and bird at their new positions.
- Sits between the bird/wall controllers, which supply positions and collision, and the VGA box-plotter datapath, which owns the frame buffer writes.
- Owns game-level sequencing: wait for go, run, and freeze on collision.

---
 rtl/frame_scheduler_pkg.sv | 53 +++++
 rtl/frame_scheduler_rect_calc.sv | 106 ++++++++++
 rtl/frame_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/frame_scheduler_pkg.sv
// frame_scheduler_pkg
// Shared definitions for the frame scheduler: FSM state encodings, plotted
// object selector, screen/sprite dimensions and the colour palette.
package frame_scheduler_pkg;

  localparam int BIRD_W_DEF = 4;
  localparam int BIRD_H_DEF = 4;
  localparam int WALL_W_DEF = 8;
  localparam int GAP_H_DEF  = 40;
  localparam int SCR_W_DEF  = 160;
  localparam int SCR_H_DEF  = 120;

  localparam logic [2:0] BG_COL_DEF   = 3'b000;
  localparam logic [2:0] BIRD_COL_DEF = 3'b110;
  localparam logic [2:0] WALL_COL_DEF = 3'b010;

  typedef enum logic [3:0] {
    ST_WAIT   = 4'd0,
    ST_IDLE   = 4'd1,
    ST_E_BIRD = 4'd2,
    ST_E_WTOP = 4'd3,
    ST_E_WBOT = 4'd4,
    ST_UPD    = 4'd5,
    ST_LATCH  = 4'd6,
    ST_D_WTOP = 4'd7,
    ST_D_WBOT = 4'd8,
    ST_D_BIRD = 4'd9,
    ST_OVER   = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    OBJ_BIRD = 2'd0,
    OBJ_WTOP = 2'd1,
    OBJ_WBOT = 2'd2
  } obj_t;

  // States that issue a rectangle to the plotter
  function automatic logic is_plot_state(input state_t s);
    logic r;
    case (s)
      ST_E_BIRD, ST_E_WTOP, ST_E_WBOT,
      ST_D_WTOP, ST_D_WBOT, ST_D_BIRD: r = 1'b1;
      default:                         r = 1'b0;
    endcase
    return r;
  endfunction

  // States that belong to a frame in progress (a tick here is an overrun)
  function automatic logic is_frame_state(input state_t s);
    return (s >= ST_E_BIRD) && (s <= ST_D_BIRD);
  endfunction

endpackage

// File: rtl/frame_scheduler_rect_calc.sv
// frame_scheduler_rect_calc
// Combinational rectangle geometry for one plotted object.
// Ports:
//   obj            which object (bird, wall top, wall bottom)
//   erase          1 = background colour, 0 = object colour
//   bird_x/bird_y  bird top-left
//   wall_x/gap_y   wall left edge and top of the gap
//   x/y/w/h/col    rectangle to plot
//   zero           rectangle has zero width or height (nothing to plot)
module frame_scheduler_rect_calc
  import frame_scheduler_pkg::*;
#(
  parameter int         BIRD_W   = BIRD_W_DEF,
  parameter int         BIRD_H   = BIRD_H_DEF,
  parameter int         WALL_W   = WALL_W_DEF,
  parameter int         GAP_H    = GAP_H_DEF,
  parameter int         SCR_W    = SCR_W_DEF,
  parameter int         SCR_H    = SCR_H_DEF,
  parameter logic [2:0] BG_COL   = BG_COL_DEF,
  parameter logic [2:0] BIRD_COL = BIRD_COL_DEF,
  parameter logic [2:0] WALL_COL = WALL_COL_DEF
) (
  input  obj_t       obj,
  input  logic       erase,
  input  logic [7:0] bird_x,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [7:0] w,
  output logic [6:0] h,
  output logic [2:0] col,
  output logic       zero
);

  logic [8:0] room_s;   // pixels left between wall_x and the right edge
  logic [8:0] ww_s;     // clipped wall width
  logic [7:0] bot_y_s;  // first row below the gap
  logic [7:0] bot_h_s;  // bottom wall height, 0 if the gap reaches the floor
  logic [8:0] w_full_s;
  logic [7:0] h_full_s;

  // Wall clipping at the right edge and bottom-wall extent
  always_comb begin
    if ({1'b0, wall_x} >= 9'(SCR_W)) begin
      room_s = 9'd0;
    end else begin
      room_s = 9'(SCR_W) - {1'b0, wall_x};
    end
    if (room_s < 9'(WALL_W)) begin
      ww_s = room_s;
    end else begin
      ww_s = 9'(WALL_W);
    end
    bot_y_s = {1'b0, gap_y} + 8'(GAP_H);
    if (bot_y_s >= 8'(SCR_H)) begin
      bot_h_s = 8'd0;
    end else begin
      bot_h_s = 8'(SCR_H) - bot_y_s;
    end
  end

  // Object select: position, size and colour of the chosen rectangle
  always_comb begin
    x        = 8'd0;
    y        = 7'd0;
    w_full_s = 9'd0;
    h_full_s = 8'd0;
    col      = BG_COL;
    case (obj)
      OBJ_BIRD: begin
        x        = bird_x;
        y        = bird_y;
        w_full_s = 9'(BIRD_W);
        h_full_s = 8'(BIRD_H);
        col      = erase ? BG_COL : BIRD_COL;
      end
      OBJ_WTOP: begin
        x        = wall_x;
        y        = 7'd0;
        w_full_s = ww_s;
        h_full_s = {1'b0, gap_y};
        col      = erase ? BG_COL : WALL_COL;
      end
      OBJ_WBOT: begin
        x        = wall_x;
        y        = bot_y_s[6:0];
        w_full_s = ww_s;
        h_full_s = bot_h_s;
        col      = erase ? BG_COL : WALL_COL;
      end
      default: begin
        x        = 8'd0;
        y        = 7'd0;
        w_full_s = 9'd0;
        h_full_s = 8'd0;
        col      = BG_COL;
      end
    endcase
    w    = w_full_s[7:0];
    h    = h_full_s[6:0];
    zero = (w_full_s == 9'd0) || (h_full_s == 8'd0);
  end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler
// Per-frame sequencer for the shared rectangle plotter: erase bird and wall,
// pulse the game logic, latch new positions, redraw wall and bird, and
// freeze in OVER after a collision.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   frame_tick, go         frame pulse, game start level
//   collision              collision level, sampled once per frame
//   bird_x/y, wall_x/gap_y positions from the controllers
//   update                 one-cycle advance pulse to the controllers
//   plot_start, plot_*     rectangle request to the plotter (held until done)
//   plot_done              plotter completion pulse
//   game_over, overrun     OVER flag, sticky dropped-tick flag
//   state                  current state encoding
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int         BIRD_W   = BIRD_W_DEF,
  parameter int         BIRD_H   = BIRD_H_DEF,
  parameter int         WALL_W   = WALL_W_DEF,
  parameter int         GAP_H    = GAP_H_DEF,
  parameter int         SCR_W    = SCR_W_DEF,
  parameter int         SCR_H    = SCR_H_DEF,
  parameter logic [2:0] BG_COL   = BG_COL_DEF,
  parameter logic [2:0] BIRD_COL = BIRD_COL_DEF,
  parameter logic [2:0] WALL_COL = WALL_COL_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       go,
  input  logic       collision,
  input  logic [7:0] bird_x,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic       update,
  output logic       plot_start,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [7:0] plot_w,
  output logic [6:0] plot_h,
  output logic [2:0] plot_col,
  input  logic       plot_done,
  output logic       game_over,
  output logic       overrun,
  output logic [3:0] state
);

  state_t     state_r, next_s;
  logic [7:0] bx_r, wx_r;
  logic [6:0] by_r, gy_r;
  logic       prev_valid_r, col_flag_r, skip_r;

  logic       adv_s, enter_plot_s, use_in_s, erase_s;
  obj_t       obj_s;
  logic [7:0] bx_s, wx_s, rx_s, rw_s;
  logic [6:0] by_s, gy_s, ry_s, rh_s;
  logic [2:0] rcol_s;
  logic       zero_s;

  assign state = state_r;

  // A plot state finishes on plot_done, or after one cycle if it had nothing to plot
  assign adv_s = skip_r || plot_done;

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_WAIT:   if (go) next_s = ST_IDLE; else next_s = ST_WAIT;
      ST_IDLE: begin
        if (frame_tick) begin
          next_s = prev_valid_r ? ST_E_BIRD : ST_UPD;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_E_BIRD: if (adv_s) next_s = ST_E_WTOP; else next_s = ST_E_BIRD;
      ST_E_WTOP: if (adv_s) next_s = ST_E_WBOT; else next_s = ST_E_WTOP;
      ST_E_WBOT: if (adv_s) next_s = ST_UPD;    else next_s = ST_E_WBOT;
      ST_UPD:    next_s = ST_LATCH;
      ST_LATCH:  next_s = ST_D_WTOP;
      ST_D_WTOP: if (adv_s) next_s = ST_D_WBOT; else next_s = ST_D_WTOP;
      ST_D_WBOT: if (adv_s) next_s = ST_D_BIRD; else next_s = ST_D_WBOT;
      ST_D_BIRD: begin
        if (adv_s) begin
          next_s = col_flag_r ? ST_OVER : ST_IDLE;
        end else begin
          next_s = ST_D_BIRD;
        end
      end
      ST_OVER:   next_s = ST_OVER;
      default:   next_s = ST_WAIT;
    endcase
  end

  // Rectangle selection for the state being entered, so the request is
  // registered on the same edge as the state change
  always_comb begin
    obj_s   = OBJ_BIRD;
    erase_s = 1'b0;
    case (next_s)
      ST_E_BIRD: begin obj_s = OBJ_BIRD; erase_s = 1'b1; end
      ST_E_WTOP: begin obj_s = OBJ_WTOP; erase_s = 1'b1; end
      ST_E_WBOT: begin obj_s = OBJ_WBOT; erase_s = 1'b1; end
      ST_D_WTOP: begin obj_s = OBJ_WTOP; erase_s = 1'b0; end
      ST_D_WBOT: begin obj_s = OBJ_WBOT; erase_s = 1'b0; end
      ST_D_BIRD: begin obj_s = OBJ_BIRD; erase_s = 1'b0; end
      default:   begin obj_s = OBJ_BIRD; erase_s = 1'b0; end
    endcase
  end

  // Leaving LATCH, the new positions are still on the inputs and only land in
  // the registers on this edge, so the first draw takes them directly
  assign use_in_s     = (state_r == ST_LATCH) && !erase_s;
  assign bx_s         = use_in_s ? bird_x : bx_r;
  assign by_s         = use_in_s ? bird_y : by_r;
  assign wx_s         = use_in_s ? wall_x : wx_r;
  assign gy_s         = use_in_s ? gap_y  : gy_r;
  assign enter_plot_s = (next_s != state_r) && is_plot_state(next_s);

  frame_scheduler_rect_calc #(
    .BIRD_W(BIRD_W), .BIRD_H(BIRD_H), .WALL_W(WALL_W), .GAP_H(GAP_H),
    .SCR_W(SCR_W), .SCR_H(SCR_H),
    .BG_COL(BG_COL), .BIRD_COL(BIRD_COL), .WALL_COL(WALL_COL)
  ) u_rect (
    .obj(obj_s), .erase(erase_s),
    .bird_x(bx_s), .bird_y(by_s), .wall_x(wx_s), .gap_y(gy_s),
    .x(rx_s), .y(ry_s), .w(rw_s), .h(rh_s), .col(rcol_s), .zero(zero_s)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= ST_WAIT;
    else         state_r <= next_s;
  end

  // Position latch. The erase pass runs before LATCH, so these registers still
  // hold what was drawn last frame when erasing; no separate copy is needed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bx_r         <= 8'd0;
      by_r         <= 7'd0;
      wx_r         <= 8'd0;
      gy_r         <= 7'd0;
      prev_valid_r <= 1'b0;
      col_flag_r   <= 1'b0;
    end else if (state_r == ST_LATCH) begin
      bx_r         <= bird_x;
      by_r         <= bird_y;
      wx_r         <= wall_x;
      gy_r         <= gap_y;
      prev_valid_r <= 1'b1;
      col_flag_r   <= collision;
    end
  end

  // Registered outputs: pulses, plot request, status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      update     <= 1'b0;
      plot_start <= 1'b0;
      plot_x     <= 8'd0;
      plot_y     <= 7'd0;
      plot_w     <= 8'd0;
      plot_h     <= 7'd0;
      plot_col   <= 3'd0;
      game_over  <= 1'b0;
      overrun    <= 1'b0;
      skip_r     <= 1'b0;
    end else begin
      update     <= (next_s == ST_UPD);
      game_over  <= (next_s == ST_OVER);
      plot_start <= enter_plot_s && !zero_s;
      if (enter_plot_s) skip_r <= zero_s;
      if (enter_plot_s && !zero_s) begin
        plot_x   <= rx_s;
        plot_y   <= ry_s;
        plot_w   <= rw_s;
        plot_h   <= rh_s;
        plot_col <= rcol_s;
      end
      // Ticks during a frame are dropped but remembered
      if (frame_tick && is_frame_state(state_r)) overrun <= 1'b1;
    end
  end

endmodule
